// File: rtl/udp_pkg.sv
// Shared defaults and the drain FSM state type for the payload drain controller.
package udp_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int QDEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_FLUSH  = 2'd3
    } drain_state_t;

endpackage

// File: rtl/desc_fifo.sv
// Small descriptor FIFO; a push into a full queue is accepted only when a pop
// frees a slot in the same cycle.
module desc_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_ok;
    logic             rd_ok;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        rd_ok    = pop && !empty;
        wr_ok    = push && (!full || rd_ok);
        wr_ptr_d = wr_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/payload_drain_ctrl.sv
// Drains queued payload frames from a 1-cycle-latency RAM into a valid/ready
// stream through a two-entry (output + skid) buffer.
//
// state  | meaning
// IDLE   | waiting for a descriptor; pops one when the queue is non-empty
// LOAD   | frame bounds known; drops zero-length frames, else reads the start word
// STREAM | reading successive words while the output buffer has room
// FLUSH  | all reads issued; waiting for the m_last word to be accepted
module payload_drain_ctrl
    import udp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int QDEPTH = QDEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_read,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              overflow,
    output logic [15:0]       frame_count
);

    drain_state_t state_q, state_d;

    logic [ADDR_W-1:0] end_q, end_d;
    logic [ADDR_W-1:0] prev_end_q, prev_end_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic              m_valid_q, m_valid_d;
    logic              m_last_q, m_last_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic              skid_last_q, skid_last_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       frame_count_q, frame_count_d;

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W-1:0] fifo_dout;

    logic [ADDR_W-1:0] start_addr;
    logic              zero_len;
    logic              out_pop;
    logic [1:0]        occ_next;
    logic              room;
    logic              issue_last;

    desc_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (QDEPTH)
    ) u_desc_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (start_read),
        .din   (last_addr),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign start_addr = prev_end_q + ADDR_W'(1);
    assign zero_len   = (end_q == prev_end_q);
    assign out_pop    = m_valid_q && m_ready;

    // Words that will still be buffered after this edge, counting the read in
    // flight; a new read is only issued if its word is guaranteed a slot.
    assign occ_next = 2'(m_valid_q) + 2'(skid_valid_q) + 2'(inflight_q) - 2'(out_pop);
    assign room     = (occ_next < 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (zero_len)                 state_d = ST_IDLE;
                else if (start_addr == end_q) state_d = ST_FLUSH;
                else                          state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (room && (cur_q == end_q)) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (out_pop && m_last_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;
        rd_en      = ((state_q == ST_LOAD) && !zero_len) ||
                     ((state_q == ST_STREAM) && room);
        rd_addr    = (state_q == ST_LOAD) ? start_addr : cur_q;
        issue_last = rd_en && (rd_addr == end_q);
        busy       = (state_q != ST_IDLE) || !fifo_empty;
    end

    always_comb begin
        end_d         = fifo_pop ? fifo_dout : end_q;
        prev_end_d    = ((state_q == ST_LOAD) && !zero_len) ? end_q : prev_end_q;
        cur_d         = cur_q;
        if (state_q == ST_LOAD) begin
            cur_d = start_addr + ADDR_W'(1);
        end else if ((state_q == ST_STREAM) && room) begin
            cur_d = cur_q + ADDR_W'(1);
        end
        inflight_d      = rd_en;
        inflight_last_d = issue_last;
        overflow_d      = overflow_q || (start_read && fifo_full && !fifo_pop);
        frame_count_d   = ((state_q == ST_FLUSH) && out_pop && m_last_q) ?
                          frame_count_q + 16'd1 : frame_count_q;

        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        m_data_d     = m_data_q;
        skid_valid_d = skid_valid_q;
        skid_last_d  = skid_last_q;
        skid_data_d  = skid_data_q;
        if (!m_valid_q || out_pop) begin
            if (skid_valid_q) begin
                m_valid_d    = 1'b1;
                m_data_d     = skid_data_q;
                m_last_d     = skid_last_q;
                skid_valid_d = inflight_q;
                skid_data_d  = rd_data;
                skid_last_d  = inflight_last_q;
            end else begin
                m_valid_d    = inflight_q;
                m_last_d     = inflight_q && inflight_last_q;
                if (inflight_q) m_data_d = rd_data;
                skid_valid_d = 1'b0;
            end
        end else if (inflight_q) begin
            skid_valid_d = 1'b1;
            skid_data_d  = rd_data;
            skid_last_d  = inflight_last_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            end_q           <= '0;
            prev_end_q      <= '1;
            cur_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            m_valid_q       <= 1'b0;
            m_last_q        <= 1'b0;
            m_data_q        <= '0;
            skid_valid_q    <= 1'b0;
            skid_last_q     <= 1'b0;
            skid_data_q     <= '0;
            overflow_q      <= 1'b0;
            frame_count_q   <= '0;
        end else begin
            end_q           <= end_d;
            prev_end_q      <= prev_end_d;
            cur_q           <= cur_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            m_valid_q       <= m_valid_d;
            m_last_q        <= m_last_d;
            m_data_q        <= m_data_d;
            skid_valid_q    <= skid_valid_d;
            skid_last_q     <= skid_last_d;
            skid_data_q     <= skid_data_d;
            overflow_q      <= overflow_d;
            frame_count_q   <= frame_count_d;
        end
    end

    assign m_valid     = m_valid_q;
    assign m_last      = m_last_q;
    assign m_data      = m_data_q;
    assign overflow    = overflow_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_payload_drain_ctrl.sv
// Randomized bench for payload_drain_ctrl: a RAM model plus a queue of expected
// beats built from frame boundaries, checked against every accepted word.
module tb_payload_drain_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int QD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_read = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready = 1'b0;
    logic          busy;
    logic          overflow;
    logic [15:0]   frame_count;

    always #5 clk = ~clk;

    payload_drain_ctrl #(.ADDR_W(AW), .DATA_W(DW), .QDEPTH(QD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_read  (start_read),
        .last_addr   (last_addr),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .busy        (busy),
        .overflow    (overflow),
        .frame_count (frame_count)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic [DW-1:0] mem [1<<AW];
    beat_t         exp_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            words_seen = 0;
    int            nz_pushed = 0;
    logic [15:0]   exp_frames = '0;
    logic [AW-1:0] prev_end = '1;
    int            ready_mode = 3;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    // RAM returns garbage whenever no read was issued the cycle before.
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : $urandom;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            2:       m_ready = ($urandom_range(0, 9) < 7);
            default: m_ready = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, prev_data);
                chk("stall_last", m_last, prev_last);
            end
            if (m_valid && m_ready) begin
                chk("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("beat_data", m_data, b.data);
                    chk("beat_last", m_last, b.last);
                    if (b.last) exp_frames++;
                end
                words_seen++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic model_clear();
        exp_q.delete();
        prev_end   = '1;
        exp_frames = '0;
        nz_pushed  = 0;
    endtask

    task automatic model_add(input logic [AW-1:0] last);
        logic [AW-1:0] a;
        if (last == prev_end) return;
        a = prev_end;
        do begin
            a = a + 1'b1;
            exp_q.push_back({mem[a], (a == last)});
        end while (a != last);
        nz_pushed++;
        prev_end = last;
    endtask

    task automatic push_desc(input logic [AW-1:0] last, input bit accepted);
        @(posedge clk);
        #1;
        start_read = 1'b1;
        last_addr  = last;
        @(posedge clk);
        #1;
        start_read = 1'b0;
        if (accepted) model_add(last);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int mode);
        int n;
        ready_mode = mode;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 4000) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("drain_busy", busy, 0);
        chk("drain_words_left", exp_q.size(), 0);
        @(posedge clk);
        #2;
        chk("frame_count", frame_count, exp_frames);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, beats, base, n;
        for (int i = 0; i < (1 << AW); i++) mem[i] = {22'($urandom), 10'(i)};

        // Reset values
        ready_mode = 3;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_count", frame_count, 0);
        rst_n = 1'b1;
        model_clear();

        // Single frame 0..7 at full rate
        ready_mode = 0;
        repeat (2) @(posedge clk);
        push_desc(10'd7, 1'b1);
        lat = 0;
        while (!m_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("first_valid_latency", lat, 3);
        beats = 1;
        while (beats < 20) begin
            @(posedge clk);
            #1;
            if (!m_valid) break;
            beats++;
        end
        chk("consecutive_beats", beats, 8);
        wait_idle(0);
        chk("single_frame_count", frame_count, 1);

        // Backpressure, alternating ready
        do_reset();
        ready_mode = 1;
        push_desc(10'd3, 1'b1);
        base = words_seen;
        wait_idle(1);
        chk("bp_transfers", words_seen - base, 4);

        // Address wrap: 1020..1023,0..3
        do_reset();
        ready_mode = 0;
        push_desc(10'd1019, 1'b1);
        wait_idle(0);
        base = words_seen;
        push_desc(10'd3, 1'b1);
        wait_idle(0);
        chk("wrap_transfers", words_seen - base, 8);

        // Overflow while the drain is stalled
        ready_mode = 3;
        push_desc(10'd23, 1'b1);
        repeat (6) @(posedge clk);
        for (int i = 0; i < 4; i++) push_desc(10'(30 + 10 * i), 1'b1);
        chk("overflow_before_drop", overflow, 0);
        push_desc(10'd70, 1'b0);
        chk("overflow_set", overflow, 1);
        wait_idle(2);
        chk("overflow_sticky", overflow, 1);

        // Zero-length descriptor behind a normal frame
        base = words_seen;
        push_desc(10'd80, 1'b1);
        push_desc(10'd80, 1'b1);
        wait_idle(0);
        chk("zero_len_transfers", words_seen - base, 20);

        // Reset in the middle of a stream
        do_reset();
        ready_mode = 0;
        push_desc(10'd7, 1'b1);
        base = words_seen;
        n = 0;
        while (words_seen < base + 2 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("reset_wait", words_seen - base >= 2, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_frame_count", frame_count, 0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_desc(10'd3, 1'b1);
        base = words_seen;
        wait_idle(0);
        chk("post_reset_transfers", words_seen - base, 4);

        // Random frames with random backpressure, at most three outstanding
        ready_mode = 2;
        for (int f = 0; f < 40; f++) begin
            int len;
            n = 0;
            while ((nz_pushed - int'(exp_frames)) >= 3 && n < 2000) begin
                @(posedge clk);
                #2;
                n++;
            end
            len = $urandom_range(1, 16);
            push_desc(AW'(prev_end + AW'(len)), 1'b1);
        end
        wait_idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
